// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - debounced seven-segment pattern to hex digit decoder
module seven_segment_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_seg,
    output logic [3:0] o_binary_num,
    output logic       o_valid,
    output logic       o_error,
    output logic       o_blank,
    output logic       o_locked
);

    localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        SETTLING,
        LOCKED
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [6:0] r_seg;
    logic [7:0] counter;
    logic [7:0] counter_next;
    logic       commit;
    logic [3:0] dec_value;
    logic       dec_legal;

    always_comb begin
        dec_value = 4'h0;
        dec_legal = 1'b1;
        case (i_seg)
            7'h7E: dec_value = 4'h0;
            7'h30: dec_value = 4'h1;
            7'h6D: dec_value = 4'h2;
            7'h79: dec_value = 4'h3;
            7'h33: dec_value = 4'h4;
            7'h5B: dec_value = 4'h5;
            7'h5F: dec_value = 4'h6;
            7'h70: dec_value = 4'h7;
            7'h7F: dec_value = 4'h8;
            7'h7B: dec_value = 4'h9;
            7'h77: dec_value = 4'hA;
            7'h1F: dec_value = 4'hB;
            7'h4E: dec_value = 4'hC;
            7'h3D: dec_value = 4'hD;
            7'h4F: dec_value = 4'hE;
            7'h47: dec_value = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    // Any disagreement with the previous sample restarts settling, even once locked.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        commit       = 1'b0;
        if (i_seg != r_seg) begin
            counter_next = 8'd0;
            state_next   = SETTLING;
        end else if (state == SETTLING) begin
            if (counter == LAST_COUNT) begin
                commit     = 1'b1;
                state_next = LOCKED;
            end else begin
                counter_next = counter + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg        <= 7'h00;
            counter      <= 8'd0;
            state        <= SETTLING;
            o_binary_num <= 4'h0;
            o_valid      <= 1'b0;
            o_error      <= 1'b0;
            o_blank      <= 1'b0;
        end else begin
            r_seg   <= i_seg;
            counter <= counter_next;
            state   <= state_next;
            o_valid <= 1'b0;
            if (commit) begin
                if (i_seg == 7'h00) begin
                    o_blank <= 1'b1;
                    o_error <= 1'b0;
                end else if (dec_legal) begin
                    o_binary_num <= dec_value;
                    o_valid      <= 1'b1;
                    o_error      <= 1'b0;
                    o_blank      <= 1'b0;
                end else begin
                    o_error <= 1'b1;
                    o_blank <= 1'b0;
                end
            end
        end
    end

    assign o_locked = (state == LOCKED);

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb/tb_seven_segment_decoder.sv - randomized bench for seven_segment_decoder against a run-length model
module tb_seven_segment_decoder;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [3:0] binary_num;
    logic       valid;
    logic       error;
    logic       blank;
    logic       locked;

    int checks = 0;
    int errors = 0;

    seven_segment_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_seg        (seg),
        .o_binary_num (binary_num),
        .o_valid      (valid),
        .o_error      (error),
        .o_blank      (blank),
        .o_locked     (locked)
    );

    always #5 clk = ~clk;

    // Digit glyphs indexed by their value.
    logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic [6:0] m_prev;
    int         m_agree;
    bit         m_locked;
    logic [3:0] m_num;
    bit         m_valid;
    bit         m_err;
    bit         m_blank;
    int         pulse_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (codes[i] == p) return i;
        return -1;
    endfunction

    // A pattern commits once it has been seen on STABLE edges in a row after its first sample.
    task automatic model_edge(input logic [6:0] s, input logic r);
        int idx;
        if (r) begin
            m_prev = 7'h00; m_agree = 0; m_locked = 0;
            m_num = 4'h0; m_valid = 0; m_err = 0; m_blank = 0;
            return;
        end
        m_valid = 0;
        if (s != m_prev) begin
            m_agree  = 0;
            m_locked = 0;
        end else if (!m_locked) begin
            m_agree++;
            if (m_agree == STABLE) begin
                m_locked = 1;
                idx = lookup(s);
                if (s == 7'h00) begin
                    m_blank = 1; m_err = 0;
                end else if (idx >= 0) begin
                    m_num = 4'(idx); m_valid = 1; m_err = 0; m_blank = 0;
                end else begin
                    m_err = 1; m_blank = 0;
                end
            end
        end
        m_prev = s;
    endtask

    task automatic step(input logic [6:0] s, input logic r);
        seg = s;
        rst = r;
        @(posedge clk);
        model_edge(s, r);
        #1;
        check("valid",  32'(valid),      32'(m_valid));
        check("num",    32'(binary_num), 32'(m_num));
        check("error",  32'(error),      32'(m_err));
        check("blank",  32'(blank),      32'(m_blank));
        check("locked", 32'(locked),     32'(m_locked));
        if (valid) pulse_count++;
    endtask

    task automatic hold(input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0);
    endtask

    initial begin
        int kind;
        int len;
        logic [6:0] pat;
        seg = 7'h00;
        rst = 1'b1;
        pulse_count = 0;

        step(7'h00, 1'b1);
        step(7'h00, 1'b1);
        hold(7'h00, 6);
        check("blank_after_reset", 32'(blank), 32'd1);
        hold(7'h6D, 8);
        hold(7'h30, 3);
        hold(7'h79, 8);
        hold(7'h5B, 6);
        hold(7'h01, 8);
        check("illegal_keeps_num", 32'(binary_num), 32'h5);

        hold(7'h47, 2);
        pulse_count = 0;
        hold(7'h47, 98);
        check("long_hold_pulses", 32'(pulse_count), 32'd1);
        pulse_count = 0;
        hold(7'h4F, 1);
        hold(7'h47, 8);
        check("reglitch_pulses", 32'(pulse_count), 32'd1);
        check("reglitch_num", 32'(binary_num), 32'hF);

        step(7'h00, 1'b1);
        hold(7'h5B, 4);
        step(7'h5B, 1'b1);
        check("reset_on_commit", 32'(valid), 32'd0);
        hold(7'h5B, 6);

        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 7));
            if (kind < 6)       pat = codes[$urandom_range(0, 15)];
            else if (kind < 8)  pat = 7'($urandom);
            else if (kind == 8) pat = 7'h00;
            else                pat = seg;
            if (kind == 9) step(pat, 1'b1);
            hold(pat, len);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_decoder.md
SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, number of consecutive agreeing samples after a change required before a pattern is committed (legal range 1..255).
REQ-002 SHALL have port i_clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_seg  input  7  segment pattern, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g, 1=lit.
REQ-005 SHALL have port o_binary_num  output  4  last committed valid digit value.
REQ-006 SHALL have port o_valid  output  1  one-cycle pulse when a valid digit is committed.
REQ-007 SHALL have port o_error  output  1  level; last committed pattern was not a legal code.
REQ-008 SHALL have port o_blank  output  1  level; last committed pattern was 7'h00.
REQ-009 SHALL have port o_locked  output  1  level; FSM in LOCKED state.

Function
REQ-010 SHALL decode: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F (hex patterns); every other nonzero pattern is illegal.
REQ-011 SHALL register i_seg into r_seg on every edge; compare i_seg with r_seg at each edge.
REQ-012 SHALL implement FSM with states SETTLING and LOCKED, plus an 8-bit settle counter.
REQ-013 On any edge where i_seg != r_seg (either state): counter <= 0, state <= SETTLING, outputs other than o_valid hold.
REQ-014 In SETTLING with i_seg == r_seg and counter < STABLE_CYCLES-1: counter increments.
REQ-015 In SETTLING with i_seg == r_seg and counter == STABLE_CYCLES-1: commit on that edge, state <= LOCKED.
REQ-016 Timing: pattern P first sampled at edge k SHALL, if unchanged through edge k+STABLE_CYCLES, commit at edge k+STABLE_CYCLES; outputs visible the cycle after.
REQ-017 Commit of legal P: o_binary_num <= decoded value, o_valid <= 1 for exactly one cycle, o_error <= 0, o_blank <= 0.
REQ-018 Commit of 7'h00: o_blank <= 1, o_error <= 0, o_binary_num holds, no o_valid pulse.
REQ-019 Commit of illegal P: o_error <= 1, o_blank <= 0, o_binary_num holds, no o_valid pulse.
REQ-020 In LOCKED with i_seg == r_seg: no state change, no further o_valid pulses regardless of duration.
REQ-021 Any change shorter than STABLE_CYCLES+1 samples SHALL produce no commit and no output change except o_locked falling.
REQ-022 o_valid SHALL be 0 on every cycle not immediately following a commit edge.
REQ-023 Re-committing the same legal value after a glitch (LOCKED->SETTLING->LOCKED) SHALL pulse o_valid again.

Reset
REQ-024 On i_rst high at an edge: r_seg <= 7'h00, counter <= 0, state <= SETTLING, o_binary_num <= 0, o_valid <= 0, o_error <= 0, o_blank <= 0, o_locked <= 0.
REQ-025 i_rst SHALL override all other activity, including a commit due on the same edge; no o_valid pulse follows a reset edge.
REQ-026 After reset release, i_seg == 7'h00 held SHALL commit blank after STABLE_CYCLES agreeing edges (r_seg reset value counts as first sample).

Verification (STABLE_CYCLES=4)
REQ-027 Reset, then i_seg=7'h6D held from edge k -> o_valid=1 only in cycle after edge k+4, o_binary_num=4'h2, o_error=0, o_locked=1.
REQ-028 i_seg=7'h30 for 3 cycles then 7'h79 held -> no commit of 1; single o_valid with o_binary_num=4'h3.
REQ-029 After committed 4'h5, i_seg=7'h01 held -> o_error=1, o_binary_num stays 4'h5, o_valid stays 0.
REQ-030 i_seg=7'h00 held after reset -> o_blank=1 four edges after release, o_valid never 1.
REQ-031 i_seg=7'h47 held 100 cycles -> exactly one o_valid pulse, o_binary_num=4'hF; one-cycle glitch to 7'h4F then back -> second o_valid pulse, value 4'hF.
REQ-032 i_rst asserted on the commit edge for 7'h5B -> all outputs 0 next cycle, no o_valid pulse.
